// File: rtl/flash_req_arbiter_pkg.sv
// Shared flash constants: quad-flash opcodes, arbiter FSM states and an
// opcode legality helper. memory_controller reuses the same opcode set.
package flash_req_arbiter_pkg;

  localparam logic [7:0] CMD_RDID      = 8'h9F;
  localparam logic [7:0] CMD_RES       = 8'hAB;
  localparam logic [7:0] CMD_WREN      = 8'h06;
  localparam logic [7:0] CMD_BE        = 8'hC7;
  localparam logic [7:0] CMD_RSR1      = 8'h05;
  localparam logic [7:0] CMD_RSR2      = 8'h07;
  localparam logic [7:0] CMD_SE        = 8'hD8;
  localparam logic [7:0] CMD_MEM_WRITE = 8'h11;
  localparam logic [7:0] CMD_FREAD     = 8'h0B;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    BUSY,
    RESP,
    DRAIN
  } arb_state_t;

  // True for opcodes the controller implements; anything else is rejected
  // before it can reach the controller.
  function automatic logic cmd_is_legal(input logic [7:0] cmd);
    case (cmd)
      CMD_RDID, CMD_RES, CMD_WREN, CMD_BE, CMD_RSR1,
      CMD_RSR2, CMD_SE, CMD_MEM_WRITE, CMD_FREAD: cmd_is_legal = 1'b1;
      default:                                    cmd_is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/flash_rr_pick.sv
// Two-way round-robin picker: with both requesters pending, the one that
// did not win last time is chosen.
module flash_rr_pick (
  input  logic [1:0] valid,
  input  logic       rr_last,
  output logic       any_valid,
  output logic       pick
);

  // Winner selection from the pending mask and the previous winner
  always_comb begin
    any_valid = |valid;
    pick      = 1'b0;
    case (valid)
      2'b01:   pick = 1'b0;
      2'b10:   pick = 1'b1;
      2'b11:   pick = ~rr_last;
      default: pick = 1'b0;
    endcase
  end

endmodule

// File: rtl/flash_req_arbiter.sv
// Shares one quad-flash memory_controller between two requesters. One whole
// command is granted at a time, the MEMTRIG/MEM_CTRL_busy handshake is run,
// a completion timeout is applied, and the result returns with a done pulse.
module flash_req_arbiter
  import flash_req_arbiter_pkg::*;
#(
  parameter int unsigned     TO_W    = 32,
  parameter logic [TO_W-1:0] TIMEOUT = TO_W'(32'h2000_0000)
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        rq0_valid,
  input  logic [7:0]  rq0_cmd,
  input  logic [23:0] rq0_addr,
  input  logic [47:0] rq0_wdata,
  output logic        rq0_done,
  input  logic        rq1_valid,
  input  logic [7:0]  rq1_cmd,
  input  logic [23:0] rq1_addr,
  input  logic [47:0] rq1_wdata,
  output logic        rq1_done,
  output logic        rsp_err,
  output logic [47:0] rsp_data,
  output logic [7:0]  MEMCMD,
  output logic [23:0] MEMADDR,
  output logic [47:0] MEMVAL,
  output logic        MEMTRIG,
  input  logic [47:0] MEMDATA,
  input  logic        MEM_CTRL_busy
);

  arb_state_t      state, state_nxt;
  logic            any_valid, pick;
  logic            gnt_id, rr_last;
  logic [TO_W-1:0] timer;
  logic            err_q, timed_out;
  logic [7:0]      sel_cmd;
  logic [23:0]     sel_addr;
  logic [47:0]     sel_wdata;
  logic            sel_legal, timer_hit;
  logic            do_grant, do_accept, do_complete, do_timeout, do_resp;

  flash_rr_pick u_pick (
    .valid     ({rq1_valid, rq0_valid}),
    .rr_last   (rr_last),
    .any_valid (any_valid),
    .pick      (pick)
  );

  // Request fields of the prospective winner and timeout detection
  always_comb begin
    sel_cmd   = pick ? rq1_cmd   : rq0_cmd;
    sel_addr  = pick ? rq1_addr  : rq0_addr;
    sel_wdata = pick ? rq1_wdata : rq0_wdata;
    sel_legal = cmd_is_legal(sel_cmd);
    timer_hit = (timer >= (TIMEOUT - TO_W'(1)));
  end

  // State register
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Per-state control strobes; completion wins over a same-cycle timeout in BUSY
  always_comb begin
    do_grant    = 1'b0;
    do_accept   = 1'b0;
    do_complete = 1'b0;
    do_timeout  = 1'b0;
    do_resp     = 1'b0;
    case (state)
      IDLE: do_grant = any_valid && !MEM_CTRL_busy;
      TRIG: begin
        if (timer_hit)          do_timeout = 1'b1;
        else if (MEM_CTRL_busy) do_accept  = 1'b1;
      end
      BUSY: begin
        if (!MEM_CTRL_busy)     do_complete = 1'b1;
        else if (timer_hit)     do_timeout  = 1'b1;
      end
      RESP:    do_resp = 1'b1;
      default: ;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (do_grant) state_nxt = sel_legal ? TRIG : RESP;
      TRIG: begin
        if (do_timeout)     state_nxt = RESP;
        else if (do_accept) state_nxt = BUSY;
      end
      BUSY:  if (do_complete || do_timeout) state_nxt = RESP;
      RESP:  state_nxt = timed_out ? DRAIN : IDLE;
      DRAIN: if (!MEM_CTRL_busy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered outputs, grant bookkeeping and the saturating timeout counter
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      rq0_done  <= 1'b0;
      rq1_done  <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
      MEMCMD    <= '0;
      MEMADDR   <= '0;
      MEMVAL    <= '0;
      MEMTRIG   <= 1'b0;
      gnt_id    <= 1'b0;
      rr_last   <= 1'b1;
      timer     <= '0;
      err_q     <= 1'b0;
      timed_out <= 1'b0;
    end else begin
      rq0_done <= 1'b0;
      rq1_done <= 1'b0;
      rsp_err  <= 1'b0;
      if (do_grant) begin
        MEMCMD    <= sel_cmd;
        MEMADDR   <= sel_addr;
        MEMVAL    <= sel_wdata;
        MEMTRIG   <= sel_legal;
        gnt_id    <= pick;
        rr_last   <= pick;
        timer     <= '0;
        err_q     <= ~sel_legal;
        timed_out <= 1'b0;
      end
      if ((state == TRIG || state == BUSY) && timer != '1)
        timer <= timer + TO_W'(1);
      if (do_accept || do_timeout)
        MEMTRIG <= 1'b0;
      if (do_complete) begin
        rsp_data <= MEMDATA;
        err_q    <= 1'b0;
      end
      if (do_timeout) begin
        err_q     <= 1'b1;
        timed_out <= 1'b1;
      end
      if (do_resp) begin
        rq0_done <= ~gnt_id;
        rq1_done <= gnt_id;
        rsp_err  <= err_q;
      end
    end
  end

endmodule

// File: tb/tb_flash_req_arbiter.sv
// Bench for flash_req_arbiter: behavioural controller model (busy while
// triggered, then for busy_len cycles, optionally forced busy), a directed
// vector table, hand-written timeout/reset sequences and random rounds.
module tb_flash_req_arbiter;

  localparam int TO = 100;

  logic        CLK = 1'b0;
  logic        reset;
  logic        rq0_valid, rq1_valid;
  logic [7:0]  rq0_cmd, rq1_cmd;
  logic [23:0] rq0_addr, rq1_addr;
  logic [47:0] rq0_wdata, rq1_wdata;
  logic        rq0_done, rq1_done, rsp_err;
  logic [47:0] rsp_data;
  logic [7:0]  MEMCMD;
  logic [23:0] MEMADDR;
  logic [47:0] MEMVAL;
  logic        MEMTRIG;
  logic [47:0] MEMDATA;
  logic        MEM_CTRL_busy;

  int unsigned checks = 0;
  int unsigned errors = 0;

  int unsigned busy_len = 0;
  int unsigned mdl_cnt  = 0;
  logic        ext_busy;

  // Reference state: previous winner and last captured response data
  bit          rr_last_m;
  logic [47:0] rsp_m;

  logic [7:0] legal_ops [9] = '{8'h9F, 8'hAB, 8'h06, 8'hC7, 8'h05, 8'h07, 8'hD8, 8'h11, 8'h0B};

  typedef struct {
    bit          v0, v1;
    logic [7:0]  c0, c1;
    int unsigned n;
    logic [47:0] data;
    int          first;
    bit          e0, e1;
  } vec_t;

  vec_t tbl [8];

  flash_req_arbiter #(.TO_W(32), .TIMEOUT(32'd100)) dut (
    .CLK           (CLK),
    .reset         (reset),
    .rq0_valid     (rq0_valid),
    .rq0_cmd       (rq0_cmd),
    .rq0_addr      (rq0_addr),
    .rq0_wdata     (rq0_wdata),
    .rq0_done      (rq0_done),
    .rq1_valid     (rq1_valid),
    .rq1_cmd       (rq1_cmd),
    .rq1_addr      (rq1_addr),
    .rq1_wdata     (rq1_wdata),
    .rq1_done      (rq1_done),
    .rsp_err       (rsp_err),
    .rsp_data      (rsp_data),
    .MEMCMD        (MEMCMD),
    .MEMADDR       (MEMADDR),
    .MEMVAL        (MEMVAL),
    .MEMTRIG       (MEMTRIG),
    .MEMDATA       (MEMDATA),
    .MEM_CTRL_busy (MEM_CTRL_busy)
  );

  always #5 CLK = ~CLK;

  // Controller model: busy immediately on trigger, then busy_len more cycles
  always @(posedge CLK) begin
    if (MEMTRIG && mdl_cnt == 0) mdl_cnt <= busy_len;
    else if (mdl_cnt != 0)       mdl_cnt <= mdl_cnt - 1;
  end
  assign MEM_CTRL_busy = MEMTRIG | (mdl_cnt != 0) | ext_busy;

  function automatic bit legal(input logic [7:0] c);
    return c inside {8'h9F, 8'hAB, 8'h06, 8'hC7, 8'h05, 8'h07, 8'hD8, 8'h11, 8'h0B};
  endfunction

  function automatic logic [7:0] rand_cmd();
    if ($urandom_range(0, 3) != 0) return legal_ops[$urandom_range(0, 8)];
    return 8'($urandom);
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One arbitration round: present the valids, then follow each granted
  // command to its done pulse. Latency: illegal = 2, legal = 3 + busy time,
  // where busy time is the trigger cycle plus n model cycles.
  task automatic run_round(input bit v0, input bit v1,
                           input logic [7:0] c0, input logic [7:0] c1,
                           input logic [23:0] a0, input logic [23:0] a1,
                           input logic [47:0] w0, input logic [47:0] w1,
                           input int unsigned n, input logic [47:0] data,
                           input int exp_first, input bit e0, input bit e1);
    int          id, lat, cnt;
    bit          e, seen;
    logic [7:0]  c;
    logic [23:0] a;
    logic [47:0] w;
    rq0_valid = v0; rq0_cmd = c0; rq0_addr = a0; rq0_wdata = w0;
    rq1_valid = v1; rq1_cmd = c1; rq1_addr = a1; rq1_wdata = w1;
    busy_len = n;
    MEMDATA  = data;
    cnt = (v0 && v1) ? 2 : 1;
    id  = exp_first;
    for (int t = 0; t < cnt; t++) begin
      if (t == 1) id = 1 - id;
      c = (id == 1) ? c1 : c0;
      a = (id == 1) ? a1 : a0;
      w = (id == 1) ? w1 : w0;
      e = (id == 1) ? e1 : e0;
      lat  = e ? 2 : 3 + (int'(n) + 1);
      seen = 1'b0;
      for (int k = 1; k <= lat + 4 && !seen; k++) begin
        @(posedge CLK); @(negedge CLK);
        if (k == 1) begin
          chk("grant_cmd", MEMCMD, c);
          chk("grant_addr", MEMADDR, a);
          chk("grant_val", MEMVAL, w);
          // inputs are sampled only at grant; scramble them afterwards
          if (id == 1) rq1_addr = ~a; else rq0_addr = ~a;
        end
        if (k <= 2) chk("memtrig", MEMTRIG, (!e && k == 1));
        if (rq0_done || rq1_done) begin
          seen = 1'b1;
          chk("done_rq0", rq0_done, id == 0);
          chk("done_rq1", rq1_done, id == 1);
          chk("done_lat", k, lat);
          chk("rsp_err", rsp_err, e);
          if (!e) rsp_m = data;
          chk("rsp_data", rsp_data, rsp_m);
          chk("addr_held", MEMADDR, a);
          if (id == 1) rq1_valid = 1'b0; else rq0_valid = 1'b0;
        end
      end
      if (!seen) begin
        checks++; errors++;
        $display("FAIL done_wait: got no done for rq%0d expected one after %0d cycles", id, lat);
        rq0_valid = 1'b0; rq1_valid = 1'b0;
      end
      rr_last_m = (id == 1);
    end
  endtask

  initial begin
    bit          seen, v0r, v1r;
    int          fr;
    logic [7:0]  c0r, c1r;
    logic [23:0] a0r, a1r;

    reset = 1'b1; ext_busy = 1'b0; MEMDATA = '0;
    rq0_valid = 1'b0; rq0_cmd = '0; rq0_addr = '0; rq0_wdata = '0;
    rq1_valid = 1'b0; rq1_cmd = '0; rq1_addr = '0; rq1_wdata = '0;
    rr_last_m = 1'b1; rsp_m = '0;
    repeat (2) @(negedge CLK);
    chk("rst_done0", rq0_done, 0);
    chk("rst_done1", rq1_done, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_cmd", MEMCMD, 0);
    chk("rst_addr", MEMADDR, 0);
    chk("rst_val", MEMVAL, 0);
    chk("rst_trig", MEMTRIG, 0);
    reset = 1'b0;
    @(negedge CLK);

    // v0 v1 c0 c1 n data first e0 e1 (winner order derived by hand from rr_last=1 at reset)
    tbl[0] = '{1'b1, 1'b1, 8'h05, 8'h05, 3, 48'h0000_0000_1111, 0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 8'h05, 8'h05, 3, 48'h0000_0000_2222, 0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 8'h9F, 8'h00, 9, 48'h0120_1803_0000, 0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 8'h00, 8'h42, 5, 48'h0000_0000_DEAD, 1, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 8'h06, 8'hC7, 0, 48'hCAFE_0000_0004, 0, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 8'hFF, 8'h0B, 2, 48'hCAFE_0000_0005, 0, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 8'h00, 8'h11, 1, 48'hCAFE_0000_0006, 1, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 8'hD8, 8'h07, 4, 48'hCAFE_0000_0007, 0, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++)
      run_round(tbl[i].v0, tbl[i].v1, tbl[i].c0, tbl[i].c1,
                24'h10_0000 + 24'(i), 24'h20_0000 + 24'(i),
                {24'hA5A5A5, 24'(i)}, {24'h5A5A5A, 24'(i)},
                tbl[i].n, tbl[i].data, tbl[i].first, tbl[i].e0, tbl[i].e1);

    // Timeout: controller never goes idle after the trigger
    rq0_valid = 1'b1; rq0_cmd = 8'h0B; rq0_addr = 24'h00ABCD; rq0_wdata = 48'h1;
    busy_len = 0;
    @(posedge CLK); @(negedge CLK);
    ext_busy = 1'b1;
    chk("to_trig", MEMTRIG, 1);
    seen = 1'b0;
    for (int k = 2; k <= TO + 6 && !seen; k++) begin
      @(posedge CLK); @(negedge CLK);
      if (k == 2) chk("to_trig_drop", MEMTRIG, 0);
      if (rq0_done || rq1_done) begin
        seen = 1'b1;
        chk("to_lat", k, TO + 2);
        chk("to_done0", rq0_done, 1);
        chk("to_err", rsp_err, 1);
        chk("to_data", rsp_data, rsp_m);
      end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL to_done: got no done expected done at cycle %0d", TO + 2);
    end
    rr_last_m = 1'b0;
    rq0_valid = 1'b0;
    rq1_valid = 1'b1; rq1_cmd = 8'h05; rq1_addr = 24'h0F0F0F; rq1_wdata = 48'h2;
    repeat (20) begin
      @(negedge CLK);
      chk("drain_trig", MEMTRIG, 0);
      chk("drain_cmd", MEMCMD, 8'h0B);
      chk("drain_done", rq1_done, 0);
    end
    ext_busy = 1'b0; rq1_valid = 1'b0;
    repeat (2) @(negedge CLK);
    run_round(1'b0, 1'b1, 8'h00, 8'h05, 24'h0, 24'h0F0F0F, 48'h0, 48'h2,
              2, 48'h0000_0BAD_F00D, 1, 1'b0, 1'b0);

    // Reset while the controller is busy with a granted command
    rq0_valid = 1'b1; rq0_cmd = 8'h9F; rq0_addr = 24'h123456; rq0_wdata = 48'h3;
    busy_len = 30;
    repeat (5) @(negedge CLK);
    chk("pre_rst_cmd", MEMCMD, 8'h9F);
    #2 reset = 1'b1;
    #1;
    chk("arst_trig", MEMTRIG, 0);
    chk("arst_cmd", MEMCMD, 0);
    chk("arst_addr", MEMADDR, 0);
    chk("arst_val", MEMVAL, 0);
    chk("arst_data", rsp_data, 0);
    rq0_valid = 1'b0;
    rr_last_m = 1'b1; rsp_m = '0;
    repeat (3) begin
      @(negedge CLK);
      chk("arst_nodone", rq0_done, 0);
    end
    reset = 1'b0;
    for (int k = 0; k < 100 && MEM_CTRL_busy; k++) begin
      @(negedge CLK);
      chk("post_rst_nodone", rq0_done, 0);
    end
    run_round(1'b1, 1'b1, 8'hAB, 8'h07, 24'h000111, 24'h000222, 48'h4, 48'h5,
              1, 48'h0000_0000_00AB, 0, 1'b0, 1'b0);

    // Reset released while the controller is still busy
    @(negedge CLK);
    reset = 1'b1; ext_busy = 1'b1;
    rq0_valid = 1'b1; rq0_cmd = 8'h9F; rq0_addr = 24'h000777; rq0_wdata = 48'h6;
    rr_last_m = 1'b1; rsp_m = '0;
    @(negedge CLK);
    reset = 1'b0;
    repeat (20) begin
      @(negedge CLK);
      chk("rel_trig", MEMTRIG, 0);
      chk("rel_cmd", MEMCMD, 0);
    end
    ext_busy = 1'b0;
    run_round(1'b1, 1'b0, 8'h9F, 8'h00, 24'h000777, 24'h0, 48'h6, 48'h0,
              3, 48'h0120_1803_0000, 0, 1'b0, 1'b0);

    // Random rounds against the reference rules
    for (int r = 0; r < 40; r++) begin
      fr  = $urandom_range(1, 3);
      v0r = fr[0]; v1r = fr[1];
      c0r = rand_cmd(); c1r = rand_cmd();
      a0r = 24'($urandom); a1r = 24'($urandom);
      fr  = (v0r && v1r) ? (rr_last_m ? 0 : 1) : (v0r ? 0 : 1);
      run_round(v0r, v1r, c0r, c1r, a0r, a1r,
                {16'($urandom), 32'($urandom)}, {16'($urandom), 32'($urandom)},
                $urandom_range(0, 6), {16'($urandom), 32'($urandom)},
                fr, !legal(c0r), !legal(c1r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
